multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port op, input, 7 bits: opcode of the latched instruction, instr[6:0].
REQ-005 The block SHALL have port funct3, input, 3 bits: instr[14:12].
REQ-006 The block SHALL have port funct7b5, input, 1 bit: instr[30].
REQ-007 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 The block SHALL have ports pcwrite, irwrite, memwrite, regwrite, adrsrc, output, 1 bit each: datapath strobes and address select.
REQ-009 The block SHALL have ports resultsrc, alusrca, alusrcb, immsrc, output, 2 bits each: datapath mux selects.
REQ-010 The block SHALL have port alucontrol, output, 3 bits, driving the ALU: 000 add, 001 sub, 010 and, 011 or.
REQ-011 The block SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode or funct3.

Function
REQ-012 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-013 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op->FETCH with illegal=1.
- MEMADR->MEMREAD on lw, ->MEMWRITE on sw.
- MEMREAD->MEMWB.
- EXECR/EXECI/JAL->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-014 FETCH SHALL drive irwrite=1, adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10, pcwrite=1.
REQ-015 DECODE SHALL drive alusrca=01, alusrcb=01, add.
REQ-016 MEMADR SHALL drive alusrca=10, alusrcb=01, add.
REQ-017 MEMREAD SHALL drive resultsrc=00, adrsrc=1.
REQ-018 MEMWB SHALL drive resultsrc=01, regwrite=1.
REQ-019 MEMWRITE SHALL drive resultsrc=00, adrsrc=1, memwrite=1.
REQ-020 EXECR SHALL drive alusrca=10, alusrcb=00; EXECI SHALL drive alusrca=10, alusrcb=01; both SHALL use funct decode (REQ-023).
REQ-021 ALUWB SHALL drive resultsrc=00, regwrite=1.
REQ-022 BEQ SHALL drive alusrca=10, alusrcb=00, sub, resultsrc=00, and pcwrite=zero (combinational on zero, same cycle).
REQ-023 Funct decode SHALL map: funct3 000 to add, or to sub when op=0110011 and funct7b5=1; 110 to or; 111 to and; any other funct3 to add with illegal=1 for that cycle, completing the instruction normally.
REQ-024 Outputs not listed for a state SHALL be 0; alucontrol SHALL default to add.
REQ-025 immsrc SHALL be combinational from op: I/load 00, S 01, B 10, J 11, else 00.
REQ-026 Every instruction SHALL take a fixed number of cycles including FETCH: lw 5, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-027 rst_n=0 SHALL force state to FETCH asynchronously; all strobes SHALL be 0 while reset is held, regardless of state.
REQ-028 Deassertion mid-instruction SHALL abandon the instruction; the first active edge SHALL begin FETCH.

Configuration
REQ-029 With JAL_EN defined, the JAL state SHALL exist and drive alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1.
REQ-030 Without JAL_EN, the JAL state SHALL NOT exist, and op 1101111 SHALL be treated as illegal (DECODE->FETCH, illegal=1).

Structure
REQ-031 Package riscv_ctrl_pkg SHALL hold the state enum, opcode constants, ALU-op codes and mux-select constants.
REQ-032 A sub-module alu_decoder SHALL implement the combinational funct decode of REQ-023.

Verification
REQ-033 Reset: hold rst_n=0 for 3 clocks in MEMREAD -> state FETCH, all strobes 0; release -> irwrite=1 on the first cycle.
REQ-034 lw: op=0000011 -> FETCH, DECODE, MEMADR, MEMREAD (adrsrc=1), MEMWB (regwrite=1), FETCH.
REQ-035 R-type: op=0110011, funct3=000, funct7b5=1 -> alucontrol=001 in EXECR; funct7b5=0 -> 000; op=0010011 with funct7b5=1 -> 000.
REQ-036 beq: zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0; returns to FETCH after 3 cycles.
REQ-037 Illegal: op=1111111 -> illegal pulses 1 cycle in DECODE, next state FETCH, no regwrite/memwrite asserted.
REQ-038 jal: with JAL_EN -> JAL then ALUWB, regwrite=1; without JAL_EN -> illegal pulse, then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
// The JAL state and opcode support exist only when JAL_EN is defined.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9
`ifdef JAL_EN
      ,
      S_JAL      = 4'd10
`endif
   } state_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic       pcupdate;
      logic       branch;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       adrsrc;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic       illegal;
   } ctrl_t;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      logic [1:0] sel;
      case (op)
         OP_SW:   sel = IMM_S;
         OP_BEQ:  sel = IMM_B;
         OP_JAL:  sel = IMM_J;
         default: sel = IMM_I;
      endcase
      return sel;
   endfunction

   function automatic logic op_supported(input logic [6:0] op);
      logic ok;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ: ok = 1'b1;
`ifdef JAL_EN
         OP_JAL:  ok = 1'b1;
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode to an ALU operation; flags unsupported funct3.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [2:0] alucontrol_o,
   output logic       illegal_o
);

   // funct decode; subtraction is only selected by R-type, never by addi
   always_comb begin
      alucontrol_o = ALU_ADD;
      illegal_o    = 1'b0;
      case (funct3_i)
         3'b000: begin
            if ((op_i == OP_RTYPE) && funct7b5_i) begin
               alucontrol_o = ALU_SUB;
            end else begin
               alucontrol_o = ALU_ADD;
            end
         end
         3'b110:  alucontrol_o = ALU_OR;
         3'b111:  alucontrol_o = ALU_AND;
         default: begin
            alucontrol_o = ALU_ADD;
            illegal_o    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle control FSM for a RISC-V subset (lw, sw, R, I, beq, jal).
// Define JAL_EN to add the JAL state; otherwise jal decodes as illegal.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       adrsrc,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   state_e     state_q;
   state_e     state_d;
   ctrl_t      ctrl_s;
   logic [2:0] dec_alu_s;
   logic       dec_illegal_s;

   alu_decoder u_alu_decoder (
      .op_i         (op),
      .funct3_i     (funct3),
      .funct7b5_i   (funct7b5),
      .alucontrol_o (dec_alu_s),
      .illegal_o    (dec_illegal_s)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
`ifdef JAL_EN
               OP_JAL:       state_d = S_JAL;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               state_d = S_MEMREAD;
            end else if (op == OP_SW) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR:   state_d = S_ALUWB;
         S_EXECI:   state_d = S_ALUWB;
`ifdef JAL_EN
         S_JAL:     state_d = S_ALUWB;
`endif
         default:   state_d = S_FETCH;
      endcase
   end

   // per-state control word; BEQ defers pcwrite to the zero flag below
   always_comb begin
      ctrl_s            = '0;
      ctrl_s.alucontrol = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ctrl_s.irwrite   = 1'b1;
            ctrl_s.pcupdate  = 1'b1;
            ctrl_s.alusrca   = SRCA_PC;
            ctrl_s.alusrcb   = SRCB_FOUR;
            ctrl_s.resultsrc = RES_ALURES;
         end
         S_DECODE: begin
            ctrl_s.alusrca = SRCA_OLDPC;
            ctrl_s.alusrcb = SRCB_IMM;
            ctrl_s.illegal = ~op_supported(op);
         end
         S_MEMADR: begin
            ctrl_s.alusrca = SRCA_RD1;
            ctrl_s.alusrcb = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl_s.resultsrc = RES_ALUOUT;
            ctrl_s.adrsrc    = 1'b1;
         end
         S_MEMWB: begin
            ctrl_s.resultsrc = RES_DATA;
            ctrl_s.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_s.resultsrc = RES_ALUOUT;
            ctrl_s.adrsrc    = 1'b1;
            ctrl_s.memwrite  = 1'b1;
         end
         S_EXECR: begin
            ctrl_s.alusrca    = SRCA_RD1;
            ctrl_s.alusrcb    = SRCB_RD2;
            ctrl_s.alucontrol = dec_alu_s;
            ctrl_s.illegal    = dec_illegal_s;
         end
         S_EXECI: begin
            ctrl_s.alusrca    = SRCA_RD1;
            ctrl_s.alusrcb    = SRCB_IMM;
            ctrl_s.alucontrol = dec_alu_s;
            ctrl_s.illegal    = dec_illegal_s;
         end
         S_ALUWB: begin
            ctrl_s.resultsrc = RES_ALUOUT;
            ctrl_s.regwrite  = 1'b1;
         end
         S_BEQ: begin
            ctrl_s.alusrca    = SRCA_RD1;
            ctrl_s.alusrcb    = SRCB_RD2;
            ctrl_s.alucontrol = ALU_SUB;
            ctrl_s.resultsrc  = RES_ALUOUT;
            ctrl_s.branch     = 1'b1;
         end
`ifdef JAL_EN
         S_JAL: begin
            ctrl_s.alusrca   = SRCA_OLDPC;
            ctrl_s.alusrcb   = SRCB_FOUR;
            ctrl_s.resultsrc = RES_ALUOUT;
            ctrl_s.pcupdate  = 1'b1;
         end
`endif
         default: begin
            ctrl_s            = '0;
            ctrl_s.alucontrol = ALU_ADD;
         end
      endcase
   end

   // Reset masks every control output: the state is already FETCH, whose strobes must not fire.
   assign pcwrite    = rst_n & (ctrl_s.pcupdate | (ctrl_s.branch & zero));
   assign irwrite    = rst_n & ctrl_s.irwrite;
   assign memwrite   = rst_n & ctrl_s.memwrite;
   assign regwrite   = rst_n & ctrl_s.regwrite;
   assign adrsrc     = rst_n & ctrl_s.adrsrc;
   assign resultsrc  = rst_n ? ctrl_s.resultsrc  : 2'b00;
   assign alusrca    = rst_n ? ctrl_s.alusrca    : 2'b00;
   assign alusrcb    = rst_n ? ctrl_s.alusrcb    : 2'b00;
   assign alucontrol = rst_n ? ctrl_s.alucontrol : ALU_ADD;
   assign illegal    = rst_n & ctrl_s.illegal;
   assign immsrc     = imm_sel(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction cycle model.
module tb_multicycle_controller;

   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pcwrite, irwrite, memwrite, regwrite, adrsrc, illegal;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;

   int          n_cmp;
   int          n_bad;
   logic [16:0] obs_vec [0:7];
   logic        zs      [0:7];

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .adrsrc(adrsrc), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] observed();
      return {pcwrite, irwrite, memwrite, regwrite, adrsrc, resultsrc, alusrca, alusrcb,
              alucontrol, illegal, immsrc};
   endfunction

   function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic mw,
                                      input logic rw, input logic adr, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic ill, input logic [1:0] imm);
      return {pcw, irw, mw, rw, adr, res, sa, sb, alu, ill, imm};
   endfunction

   function automatic bit jal_on();
`ifdef JAL_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Cycle count per instruction class, FETCH included; unsupported opcodes stop after DECODE.
   function automatic int n_cycles(input logic [6:0] o);
      if (o == 7'b0000011) return 5;
      if (o == 7'b0100011) return 4;
      if (o == 7'b0110011 || o == 7'b0010011) return 4;
      if (o == 7'b1100011) return 3;
      if (o == 7'b1101111 && jal_on()) return 4;
      return 2;
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == 7'b0100011) return 2'b01;
      if (o == 7'b1100011) return 2'b10;
      if (o == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   // Expected outputs for cycle k of an instruction.
   function automatic logic [16:0] expect_vec(input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic z, input int k);
      logic [1:0] im;
      logic [2:0] alu;
      logic       bad;
      im = imm_of(o);
      if (k == 0) return mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 0, im);
      if (k == 1) return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, n_cycles(o) == 2, im);
      if (o == 7'b0000011 || o == 7'b0100011) begin
         if (k == 2) return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 0, im);
         if (o == 7'b0100011) return mk(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, im);
         if (k == 3) return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, im);
         return mk(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'd0, 0, im);
      end
      if (o == 7'b0110011 || o == 7'b0010011) begin
         if (k == 3) return mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0, im);
         bad = 1'b0;
         if (f3 == 3'd0) alu = (o == 7'b0110011 && f7) ? 3'd1 : 3'd0;
         else if (f3 == 3'd6) alu = 3'd3;
         else if (f3 == 3'd7) alu = 3'd2;
         else begin alu = 3'd0; bad = 1'b1; end
         return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0110011) ? 2'b00 : 2'b01, alu, bad, im);
      end
      if (o == 7'b1100011) return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, 0, im);
      if (k == 2) return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, 0, im);
      return mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0, im);
   endfunction

   // Entry: just after a rising edge with the DUT in FETCH. zmode 0/1 fixes zero, 2 randomizes.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int n, input int zmode);
      op = o; funct3 = f3; funct7b5 = f7;
      for (int k = 0; k < n; k++) begin
         zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         zs[k] = zero;
         @(negedge clk);
         obs_vec[k] = observed();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [16:0] zv;
      op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      zv = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0, 2'b00);
      @(negedge clk);
      n_cmp++;
      if (observed() !== zv) begin
         n_bad++; $display("FAIL reset_init: got %b want %b", observed(), zv);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      // walk a lw into MEMREAD, then reset there
      run_instr(7'b0000011, 3'd2, 1'b0, 3, 2);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expect_vec(7'b0000011, 3'd2, 1'b0, 1'b0, 3)) begin
         n_bad++; $display("FAIL reset_memread: got %b want %b", observed(), expect_vec(7'b0000011, 3'd2, 1'b0, 1'b0, 3));
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (observed() !== zv) begin
         n_bad++; $display("FAIL reset_async: got %b want %b", observed(), zv);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (observed() !== zv) begin
            n_bad++; $display("FAIL reset_hold%0d: got %b want %b", c, observed(), zv);
         end
      end
      @(posedge clk); #1; rst_n = 1'b1;
      run_instr(7'b0000011, 3'd2, 1'b0, 5, 2);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (obs_vec[k] !== expect_vec(7'b0000011, 3'd2, 1'b0, zs[k], k)) begin
            n_bad++; $display("FAIL reset_release c%0d: got %b want %b", k, obs_vec[k], expect_vec(7'b0000011, 3'd2, 1'b0, zs[k], k));
         end
      end
   endtask

   task automatic test_mem();
      logic [6:0] ops [2];
      ops[0] = 7'b0000011; ops[1] = 7'b0100011;
      for (int i = 0; i < 2; i++) begin
         run_instr(ops[i], 3'd2, 1'b0, n_cycles(ops[i]), 2);
         for (int k = 0; k < n_cycles(ops[i]); k++) begin
            n_cmp++;
            if (obs_vec[k] !== expect_vec(ops[i], 3'd2, 1'b0, zs[k], k)) begin
               n_bad++; $display("FAIL mem op=%b c%0d: got %b want %b", ops[i], k, obs_vec[k], expect_vec(ops[i], 3'd2, 1'b0, zs[k], k));
            end
         end
      end
   endtask

   task automatic test_alu();
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7;
      for (int i = 0; i < 12; i++) begin
         o  = (i < 6) ? 7'b0110011 : 7'b0010011;
         f3 = (i % 6 == 0 || i % 6 == 1) ? 3'd0 : (i % 6 == 2) ? 3'd6 : (i % 6 == 3) ? 3'd7 : (i % 6 == 4) ? 3'd1 : 3'd5;
         f7 = (i % 2 == 0);
         run_instr(o, f3, f7, 4, 2);
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_vec[k] !== expect_vec(o, f3, f7, zs[k], k)) begin
               n_bad++; $display("FAIL alu op=%b f3=%b f7=%b c%0d: got %b want %b", o, f3, f7, k, obs_vec[k], expect_vec(o, f3, f7, zs[k], k));
            end
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 0; z < 2; z++) begin
         run_instr(7'b1100011, 3'd0, 1'b0, 3, z);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs_vec[k] !== expect_vec(7'b1100011, 3'd0, 1'b0, zs[k], k)) begin
               n_bad++; $display("FAIL beq z=%0d c%0d: got %b want %b", z, k, obs_vec[k], expect_vec(7'b1100011, 3'd0, 1'b0, zs[k], k));
            end
         end
      end
   endtask

   task automatic test_illegal_jal();
      logic [6:0] ops [2];
      ops[0] = 7'b1111111; ops[1] = 7'b1101111;
      for (int i = 0; i < 2; i++) begin
         run_instr(ops[i], 3'd0, 1'b0, n_cycles(ops[i]), 2);
         for (int k = 0; k < n_cycles(ops[i]); k++) begin
            n_cmp++;
            if (obs_vec[k] !== expect_vec(ops[i], 3'd0, 1'b0, zs[k], k)) begin
               n_bad++; $display("FAIL ill_jal op=%b c%0d: got %b want %b", ops[i], k, obs_vec[k], expect_vec(ops[i], 3'd0, 1'b0, zs[k], k));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7;
      int         n;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0:       o = 7'b0000011;
            1:       o = 7'b0100011;
            2:       o = 7'b0110011;
            3:       o = 7'b0010011;
            4:       o = 7'b1100011;
            5:       o = 7'b1101111;
            default: o = 7'($urandom_range(0, 127));
         endcase
         f3 = 3'($urandom_range(0, 7));
         f7 = 1'($urandom_range(0, 1));
         n  = n_cycles(o);
         run_instr(o, f3, f7, n, 2);
         for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (obs_vec[k] !== expect_vec(o, f3, f7, zs[k], k)) begin
               n_bad++; $display("FAIL rand i=%0d op=%b f3=%b c%0d: got %b want %b", i, o, f3, k, obs_vec[k], expect_vec(o, f3, f7, zs[k], k));
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0;
      test_reset();
      test_mem();
      test_alu();
      test_beq();
      test_illegal_jal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
